// File: rtl/ac_mode_sequencer.sv
// Air-conditioning mode sequencer: threshold/hysteresis control of heater and
// cooler drives with minimum-run protection and an all-off dwell between runs.
`timescale 1ns/1ps

module ac_mode_sequencer #(
   parameter int MIN_RUN = 8,
   parameter int DWELL   = 4,
   parameter int HYST    = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [4:0] temperature,
   input  logic       temp_valid,
   input  logic [4:0] heat_thresh,
   input  logic [4:0] cool_thresh,
   output logic       heating,
   output logic       cooling,
   output logic [1:0] mode,
   output logic       fault
);

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_HEAT  = 2'b01,
      ST_COOL  = 2'b10,
      ST_DWELL = 2'b11
   } state_t;

   localparam int RUN_W   = $clog2(MIN_RUN + 1);
   localparam int DWELL_W = $clog2(DWELL + 1);

   localparam logic [RUN_W-1:0]   RUN_LAST   = RUN_W'(MIN_RUN - 1);
   localparam logic [RUN_W-1:0]   RUN_MAX    = RUN_W'(MIN_RUN);
   localparam logic [RUN_W-1:0]   RUN_ONE    = RUN_W'(1);
   localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(DWELL);
   localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
   localparam logic [5:0]         HYST6      = 6'(HYST);

   state_t               state;
   state_t               state_nx;
   logic [RUN_W-1:0]     run_cnt;
   logic [DWELL_W-1:0]   dwell_cnt;

   // Widened to 6 bits so threshold +/- hysteresis never wraps.
   logic [5:0] temp6;
   logic [5:0] heat6;
   logic [5:0] cool6;
   logic       heat_on;
   logic       cool_on;
   logic       heat_off;
   logic       cool_off;
   logic       run_done;
   logic       dwell_done;
   logic       force_exit;

   assign temp6 = {1'b0, temperature};
   assign heat6 = {1'b0, heat_thresh};
   assign cool6 = {1'b0, cool_thresh};

   assign heat_on    = (temp6 <= heat6);
   assign cool_on    = (temp6 >= cool6);
   assign heat_off   = (temp6 > (heat6 + HYST6));
   assign cool_off   = ((temp6 + HYST6) < cool6);
   assign run_done   = (run_cnt >= RUN_LAST);
   assign dwell_done = (dwell_cnt == DWELL_LAST);
   assign force_exit = !enable || fault;

   // NOTE: next-state is given a default before the case so no path leaves it
   // unassigned; an unassigned path would infer a latch.
   always_comb begin
      state_nx = state;
      case (state)
         ST_OFF: begin
            if (enable && temp_valid && !fault) begin
               if (heat_on)
                  state_nx = ST_HEAT;
               else if (cool_on)
                  state_nx = ST_COOL;
            end
         end
         ST_HEAT: begin
            if (force_exit)
               state_nx = ST_DWELL;
            else if (run_done && temp_valid && heat_off)
               state_nx = ST_DWELL;
         end
         ST_COOL: begin
            if (force_exit)
               state_nx = ST_DWELL;
            else if (run_done && temp_valid && cool_off)
               state_nx = ST_DWELL;
         end
         ST_DWELL: begin
            if (dwell_done)
               state_nx = ST_OFF;
         end
         default: state_nx = ST_OFF;
      endcase
   end

   // NOTE: all state updates use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_OFF;
         run_cnt   <= '0;
         dwell_cnt <= '0;
         fault     <= 1'b0;
      end else begin
         state <= state_nx;
         fault <= (heat_thresh >= cool_thresh);
         if (state_nx != state) begin
            // Every state entry restarts both timers.
            run_cnt   <= '0;
            dwell_cnt <= '0;
         end else begin
            if ((state == ST_HEAT || state == ST_COOL) && run_cnt != RUN_MAX)
               run_cnt <= run_cnt + RUN_ONE;
            if (state == ST_DWELL && dwell_cnt != DWELL_MAX)
               dwell_cnt <= dwell_cnt + DWELL_ONE;
         end
      end
   end

   assign heating = (state == ST_HEAT);
   assign cooling = (state == ST_COOL);
   assign mode    = state;

endmodule

// File: tb/tb_ac_mode_sequencer.sv
// Self-checking bench for ac_mode_sequencer: scenario tasks push expected
// post-edge state into a scoreboard that a negedge monitor pops and compares.
`timescale 1ns/1ps

module tb_ac_mode_sequencer;

   localparam logic [1:0] M_OFF   = 2'b00;
   localparam logic [1:0] M_HEAT  = 2'b01;
   localparam logic [1:0] M_COOL  = 2'b10;
   localparam logic [1:0] M_DWELL = 2'b11;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [4:0] temperature;
   logic       temp_valid;
   logic [4:0] heat_thresh;
   logic [4:0] cool_thresh;
   logic       heating;
   logic       cooling;
   logic [1:0] mode;
   logic       fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [1:0] mode;
      logic       fault;
      string      name;
   } exp_t;

   exp_t sb[$];

   ac_mode_sequencer #(.MIN_RUN(8), .DWELL(4), .HYST(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .temperature (temperature),
      .temp_valid  (temp_valid),
      .heat_thresh (heat_thresh),
      .cool_thresh (cool_thresh),
      .heating     (heating),
      .cooling     (cooling),
      .mode        (mode),
      .fault       (fault)
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: outputs are registered, so the negedge after the
   // edge that queued an expectation is where it is compared.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         logic [4:0] got;
         logic [4:0] want;
         e    = sb.pop_front();
         got  = {mode, heating, cooling, fault};
         want = {e.mode, (e.mode == M_HEAT), (e.mode == M_COOL), e.fault};
         checks++;
         if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got mode=%b heat=%b cool=%b fault=%b expected mode=%b heat=%b cool=%b fault=%b",
                     e.name, $time, got[4:3], got[2], got[1], got[0],
                     want[4:3], want[2], want[1], want[0]);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   // Let one rising edge happen, queue what must be visible after it, then
   // return at the following falling edge where new stimulus is applied.
   task automatic cyc(input logic [1:0] m, input logic f, input string name);
      exp_t e;
      @(posedge clk);
      e.mode  = m;
      e.fault = f;
      e.name  = name;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic run(input int n, input logic [1:0] m, input logic f, input string name);
      for (int i = 0; i < n; i++)
         cyc(m, f, name);
   endtask

   task automatic set_defaults();
      enable      = 1'b1;
      heat_thresh = 5'd18;
      cool_thresh = 5'd22;
      temp_valid  = 1'b0;
      temperature = 5'd20;
   endtask

   task automatic do_reset();
      set_defaults();
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      set_defaults();
      rst         = 1'b1;
      temperature = 5'd10;
      temp_valid  = 1'b1;
      #1;
      checks++;
      if ({mode, heating, cooling, fault} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_initial got mode=%b heat=%b cool=%b fault=%b expected all 0",
                  mode, heating, cooling, fault);
      end
      run(3, M_OFF, 1'b0, "reset_held");
      rst = 1'b0;
      cyc(M_HEAT, 1'b0, "reset_release_heat");
   endtask

   task automatic test_full_cycle();
      do_reset();
      temperature = 5'd17;
      temp_valid  = 1'b1;
      cyc(M_HEAT, 1'b0, "full_enter_heat");
      cyc(M_HEAT, 1'b0, "full_heat_c2");
      temperature = 5'd25;
      run(6, M_HEAT, 1'b0, "full_min_run_hold");
      run(4, M_DWELL, 1'b0, "full_dwell");
      cyc(M_OFF, 1'b0, "full_off");
      cyc(M_COOL, 1'b0, "full_cool");
   endtask

   task automatic test_hysteresis();
      do_reset();
      temperature = 5'd17;
      temp_valid  = 1'b1;
      cyc(M_HEAT, 1'b0, "hyst_enter_heat");
      temperature = 5'd19;
      run(10, M_HEAT, 1'b0, "hyst_heat_19_holds");
      temperature = 5'd20;
      cyc(M_DWELL, 1'b0, "hyst_heat_20_exit");
      run(3, M_DWELL, 1'b0, "hyst_heat_dwell");
      run(2, M_OFF, 1'b0, "hyst_off_deadband");
      temperature = 5'd23;
      cyc(M_COOL, 1'b0, "hyst_enter_cool");
      temperature = 5'd21;
      run(10, M_COOL, 1'b0, "hyst_cool_21_holds");
      temperature = 5'd20;
      cyc(M_DWELL, 1'b0, "hyst_cool_20_exit");
      run(3, M_DWELL, 1'b0, "hyst_cool_dwell");
      cyc(M_OFF, 1'b0, "hyst_cool_off");
   endtask

   task automatic test_valid_gating();
      do_reset();
      temperature = 5'd10;
      temp_valid  = 1'b0;
      run(20, M_OFF, 1'b0, "gate_invalid_off");
      temp_valid = 1'b1;
      cyc(M_HEAT, 1'b0, "gate_single_valid");
      temp_valid  = 1'b0;
      temperature = 5'd30;
      run(12, M_HEAT, 1'b0, "gate_invalid_no_exit");
   endtask

   task automatic test_forced_exit_fault();
      do_reset();
      temperature = 5'd17;
      temp_valid  = 1'b1;
      cyc(M_HEAT, 1'b0, "force_enter_heat");
      cyc(M_HEAT, 1'b0, "force_heat_c2");
      enable = 1'b0;
      cyc(M_DWELL, 1'b0, "force_enable_low");
      run(3, M_DWELL, 1'b0, "force_dwell");
      run(2, M_OFF, 1'b0, "force_disabled_off");
      enable = 1'b1;

      temp_valid  = 1'b0;
      heat_thresh = 5'd22;
      cool_thresh = 5'd18;
      cyc(M_OFF, 1'b1, "fault_raise");
      temperature = 5'd10;
      temp_valid  = 1'b1;
      run(4, M_OFF, 1'b1, "fault_blocks_heat");

      temp_valid  = 1'b0;
      heat_thresh = 5'd20;
      cool_thresh = 5'd20;
      cyc(M_OFF, 1'b1, "fault_equal_thresh");

      heat_thresh = 5'd18;
      cool_thresh = 5'd22;
      cyc(M_OFF, 1'b0, "fault_clear");
      temperature = 5'd25;
      temp_valid  = 1'b1;
      cyc(M_COOL, 1'b0, "fault_enter_cool");
      heat_thresh = 5'd22;
      cool_thresh = 5'd18;
      cyc(M_COOL, 1'b1, "fault_reg_delay");
      cyc(M_DWELL, 1'b1, "fault_forces_dwell");
      run(3, M_DWELL, 1'b1, "fault_dwell");
      cyc(M_OFF, 1'b1, "fault_off_held");
   endtask

   task automatic test_async_reset();
      do_reset();
      temperature = 5'd25;
      temp_valid  = 1'b1;
      cyc(M_COOL, 1'b0, "arst_enter_cool");
      cyc(M_COOL, 1'b0, "arst_cool_c2");
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (cooling !== 1'b0 || mode !== M_OFF) begin
         errors++;
         $display("FAIL arst_immediate got cooling=%b mode=%b expected cooling=0 mode=00",
                  cooling, mode);
      end
      #1;
      rst = 1'b0;
      cyc(M_COOL, 1'b0, "arst_no_dwell");
   endtask

   initial begin
      test_reset();
      test_full_cycle();
      test_hysteresis();
      test_valid_gating();
      test_forced_exit_fault();
      test_async_reset();
      #1;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
